// File: rtl/vector_slice_pkg.sv
`default_nettype none
// ============================================================================
// vector_slice_pkg: shared defaults and state encoding for vector_slice_sched
// Rev 1.0
// ============================================================================
package vector_slice_pkg;

  localparam int DEF_NUM_SLICES = 3;
  localparam int DEF_SLICE_W    = 12;
  localparam int DEF_IDX_W      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/slice_unit.sv
`default_nettype none
// ============================================================================
// slice_unit: combinational per-4-bit-group inverter / OAI222 slice function
// Rev 1.0
// ============================================================================
module slice_unit
  import vector_slice_pkg::*;
#(
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic [SLICE_W-1:0] c
);

  localparam int NUM_GROUPS = SLICE_W / 4;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
    assign c[4*g]   = ~a[4*g];
    assign c[4*g+1] = ~b[4*g];
    assign c[4*g+2] = ~b[4*g+1];
    // Single OAI222 term.
    assign c[4*g+3] = ~((a[4*g+1] | a[4*g+2]) &
                        (b[4*g+1] | b[4*g+2]) &
                        (a[4*g+3] | b[4*g+3]));
  end

endmodule
`default_nettype wire

// File: rtl/vector_slice_sched.sv
`default_nettype none
// ============================================================================
// vector_slice_sched: runs a wide operand pair through one shared slice_unit,
// one lane per cycle, and returns the assembled result on valid/ready.
// Rev 1.0
// ============================================================================
module vector_slice_sched
  import vector_slice_pkg::*;
#(
  parameter int NUM_SLICES = DEF_NUM_SLICES,
  parameter int SLICE_W    = DEF_SLICE_W,
  parameter int IDX_W      = DEF_IDX_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_SLICES*SLICE_W-1:0] in_a,
  input  logic [NUM_SLICES*SLICE_W-1:0] in_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_SLICES*SLICE_W-1:0] out_c,
  output logic                          busy,
  output logic [IDX_W-1:0]              slice_idx
);

  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_SLICES - 1);

  state_t                               r_state;
  state_t                               w_state_nxt;
  logic [IDX_W-1:0]                     r_idx;
  logic [NUM_SLICES-1:0][SLICE_W-1:0]   r_a;
  logic [NUM_SLICES-1:0][SLICE_W-1:0]   r_b;
  logic [NUM_SLICES-1:0][SLICE_W-1:0]   r_c;
  logic [SLICE_W-1:0]                   w_slice_c;
  logic                                 w_accept;
  logic                                 w_last;

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign out_c     = r_c;
  assign slice_idx = r_idx;
  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_last    = (r_idx == C_LAST_IDX);

  slice_unit #(
    .SLICE_W (SLICE_W)
  ) u_slice_unit (
    .a (r_a[r_idx]),
    .b (r_b[r_idx]),
    .c (w_slice_c)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        // Abort keeps the result register; only sequencing is reset.
        r_idx <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_a   <= in_a;
              r_b   <= in_b;
              r_idx <= '0;
            end
          end
          RUN: begin
            r_c[r_idx] <= w_slice_c;
            r_idx      <= w_last ? '0 : r_idx + 1'b1;
          end
          DONE:    r_idx <= '0;
          default: r_idx <= '0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vector_slice_sched.sv
`default_nettype none
// ============================================================================
// tb_vector_slice_sched: table-driven and scoreboard bench for vector_slice_sched
// Rev 1.0
// ============================================================================
module tb_vector_slice_sched;

  localparam int W = 36;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_c;
  logic         busy;
  logic [1:0]   slice_idx;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] sb[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  vector_slice_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .busy      (busy),
    .slice_idx (slice_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] c;
    for (int g = 0; g < W / 4; g++) begin
      c[4*g]   = ~a[4*g];
      c[4*g+1] = ~b[4*g];
      c[4*g+2] = ~b[4*g+1];
      c[4*g+3] = ~((a[4*g+1] | a[4*g+2]) & (b[4*g+1] | b[4*g+2]) & (a[4*g+3] | b[4*g+3]));
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output-side scoreboard: compare on every completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", out_c, 'x);
      end else begin
        check("out_c", out_c, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input logic [W-1:0] exp);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("accept_ready", {35'd0, in_ready}, 36'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    if (push) sb.push_back(exp);
    #1;
    in_valid = 1'b0;
    // Scrambled inputs during RUN must not reach the operand registers.
    in_a = 36'({$urandom(), $urandom()});
    in_b = 36'({$urandom(), $urandom()});
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
    int n = 0;
    accept(a, b, 1'b1, exp);
    while (!out_valid && n < 20) begin
      check("slice_idx_seq", {34'd0, slice_idx}, W'(n));
      check("busy_run", {35'd0, busy}, 36'd1);
      tick();
      n++;
    end
    check("latency", W'(n), 36'd3);
    tick();
    check("idle_after_done", {34'd0, out_valid, in_ready}, 36'b01);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{36'h000000000, 36'h000000000, 36'hFFFFFFFFF};
    vecs[1] = '{36'hFFFFFFFFF, 36'h000000000, 36'hEEEEEEEEE};
    vecs[2] = '{36'h000000000, 36'hFFFFFFFFF, 36'h999999999};
    vecs[3] = '{36'hFFFFFFFFF, 36'hFFFFFFFFF, 36'h000000000};
    for (int i = 4; i < 7; i++) begin
      vecs[i].a   = 36'({$urandom(), $urandom()});
      vecs[i].b   = 36'({$urandom(), $urandom()});
      vecs[i].exp = model(vecs[i].a, vecs[i].b);
    end

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_out_valid", {35'd0, out_valid}, 36'd0);
    check("rst_in_ready", {35'd0, in_ready}, 36'd1);
    check("rst_busy", {35'd0, busy}, 36'd0);
    check("rst_out_c", out_c, 36'd0);
    check("rst_slice_idx", {34'd0, slice_idx}, 36'd0);

    for (int i = 0; i < 7; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].exp);

    // Output stall: result must hold for any stall length.
    out_ready = 1'b0;
    accept(36'hFFFFFFFFF, 36'hFFFFFFFFF, 1'b1, 36'h000000000);
    for (int n = 0; n < 20 && !out_valid; n++) tick();
    for (int n = 0; n < 10; n++) begin
      check("stall_out_c", out_c, 36'h000000000);
      check("stall_flags", {33'd0, out_valid, in_ready, busy}, 36'b101);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("stall_release", {34'd0, out_valid, in_ready}, 36'b01);

    // Abort mid-run: out_valid must never rise.
    accept(36'h123456789, 36'h987654321, 1'b0, '0);
    tick();
    check("flush_at_idx1", {34'd0, slice_idx}, 36'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_state", {33'd0, busy, in_ready, out_valid}, 36'b010);
    check("flush_idx", {34'd0, slice_idx}, 36'd0);
    begin
      logic seen = 1'b0;
      for (int n = 0; n < 6; n++) begin
        seen |= out_valid;
        tick();
      end
      check("flush_no_valid", {35'd0, seen}, 36'd0);
    end
    run_op(36'h000000000, 36'h000000000, 36'hFFFFFFFFF);

    // Flush together with in_valid in IDLE: no accept.
    in_valid = 1'b1; flush = 1'b1;
    in_a = 36'hFFFFFFFFF; in_b = 36'h0;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", {35'd0, busy}, 36'd0);

    // Asynchronous reset mid-run.
    accept(36'hFFFFFFFFF, 36'h000000000, 1'b0, '0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_flags", {33'd0, out_valid, in_ready, busy}, 36'b010);
    check("arst_idx", {34'd0, slice_idx}, 36'd0);
    check("arst_out_c", out_c, 36'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(36'hFFFFFFFFF, 36'h000000000, 36'hEEEEEEEEE);

    repeat (3) tick();
    check("sb_drained", W'(sb.size()), 36'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
